buffer_arbiter: RTL



---
 rtl/buffer_arbiter_pkg.sv | 18 +
 rtl/buffer_arbiter_rr_pick.sv | 29 ++
 rtl/buffer_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/buffer_arbiter_pkg.sv
// rtl/buffer_arbiter_pkg.sv - shared state encoding and sizing helper for buffer_arbiter
package buffer_arbiter_pkg;

  // Two-state grant FSM
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Bits needed to index n items, never less than one so N=1 still has a register
  function automatic int clog2_min1(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/buffer_arbiter_rr_pick.sv
// rtl/buffer_arbiter_rr_pick.sv - combinational round-robin search starting at ptr
module rr_pick
  import buffer_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          any
);

  // Walk ptr, ptr+1, ... wrapping; iterate backwards so the nearest hit wins
  always_comb begin
    int c;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = (int'(ptr) + k) % N;
      if (req[c]) begin
        idx = PW'(c);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/buffer_arbiter.sv
// rtl/buffer_arbiter.sv - round-robin arbiter sharing one registered output buffer
module buffer_arbiter
  import buffer_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] din,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   s,
  output logic           valid,
  output logic           busy
);

  localparam int PW = clog2_min1(N);
  localparam int HW = clog2_min1(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(N - 1);

  state_e        state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] idx_q;
  logic [HW-1:0] hold_q;
  logic [N-1:0]  gnt_q;
  logic [W-1:0]  s_q;
  logic          valid_q;

  logic [PW-1:0] pick_idx;
  logic          pick_any;
  logic [N-1:0]  onehot_d;
  logic [PW-1:0] ptr_d;
  logic [W-1:0]  data_d;

  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Grant vector for the winner, next round-robin start, and the granted data slice
  always_comb begin
    onehot_d = '0;
    for (int i = 0; i < N; i++) begin
      onehot_d[i] = (pick_idx == PW'(i));
    end
    ptr_d  = (idx_q == PTR_LAST) ? '0 : idx_q + 1'b1;
    data_d = din[int'(idx_q) * W +: W];
  end

  // Grant FSM: arbitrate in IDLE, transfer or release in GRANT; a grant end always returns to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (pick_any) begin
            gnt_q   <= onehot_d;
            idx_q   <= pick_idx;
            hold_q  <= '0;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (!req[idx_q]) begin
            // Release wins over hold expiry: no transfer on this edge
            gnt_q   <= '0;
            valid_q <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end else begin
            s_q     <= data_d;
            valid_q <= 1'b1;
            if (hold_q == HOLD_LAST) begin
              gnt_q   <= '0;
              ptr_q   <= ptr_d;
              hold_q  <= '0;
              state_q <= IDLE;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign valid = valid_q;
  assign busy  = (state_q == GRANT);

endmodule
